card_draw_gen: RTL and testbench

- Parametrised successor to the 1..10 free-running random counter used by the BlackJack game.
- Values cycle over 1..RANGE while enabled. A draw request samples the running value and deals it only if that value still has copies left in a finite deck, so a value is never over-dealt.
- If the sampled value is exhausted, the block searches forward to the next available value.
- Sits between the player/dealer control FSM and the hex/LED display path.

---
 rtl/card_gen_pkg.sv | 28 ++
 rtl/card_value_counter.sv | 42 ++++
 rtl/card_draw_gen.sv | 121 ++++++++++++
 tb/tb_card_draw_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/card_gen_pkg.sv
// card_gen_pkg: shared types and helpers for the card draw generator.
// Holds the FSM state enum, LFSR constants and the 1..limit wrap helper.
package card_gen_pkg;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Advance value by step inside 1..limit; 0 is never produced
    // as long as value is already in range.
    function automatic logic [15:0] wrap_inc(
        input logic [15:0] value,
        input logic [1:0]  step,
        input logic [15:0] limit
    );
        logic [16:0] sum;
        sum = 17'(value) + 17'(step);
        if (sum > 17'(limit))
            sum = sum - 17'(limit);
        return sum[15:0];
    endfunction

endpackage

// File: rtl/card_value_counter.sv
// card_value_counter: free-running 1..RANGE value counter.
// Ports: clock, reset_n (async low), enable -> count.
// CARD_DRAW_GEN_LFSR_EN adds an LFSR that makes some steps 2.
module card_value_counter
    import card_gen_pkg::*;
#(
    parameter int VAL_W = 5,
    parameter int RANGE = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    output logic [VAL_W-1:0] count
);

    logic [1:0] step;

`ifdef CARD_DRAW_GEN_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            lfsr <= LFSR_SEED;
        else if (lfsr[0])
            lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
        else
            lfsr <= lfsr >> 1;
    end

    assign step = lfsr[0] ? 2'd2 : 2'd1;
`else
    assign step = 2'd1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= VAL_W'(1);
        else if (enable)
            count <= VAL_W'(wrap_inc(16'(count), step, 16'(RANGE)));
    end

endmodule

// File: rtl/card_draw_gen.sv
// card_draw_gen: deals 1..RANGE values from a finite deck of COPIES each.
// Ports: clock, reset_n, enable, shuffle, draw_req -> draw_ready, card,
//        card_valid, remaining, empty. Option: CARD_DRAW_GEN_LFSR_EN.
module card_draw_gen
    import card_gen_pkg::*;
#(
    parameter int VAL_W  = 5,
    parameter int RANGE  = 10,
    parameter int COPIES = 4,
    parameter int REM_W  = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             shuffle,
    input  logic             draw_req,
    output logic             draw_ready,
    output logic [VAL_W-1:0] card,
    output logic             card_valid,
    output logic [REM_W-1:0] remaining,
    output logic             empty
);

    localparam int CNT_W = $clog2(COPIES + 1);
    localparam logic [REM_W-1:0] TOTAL = REM_W'(RANGE * COPIES);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(COPIES);

    state_t           state;
    state_t           next_state;
    logic [VAL_W-1:0] count;
    logic [VAL_W-1:0] cand;
    logic [CNT_W-1:0] used [RANGE];
    logic [CNT_W-1:0] cand_used;
    logic             avail;
    logic             accept;
    logic             deal;

    card_value_counter #(
        .VAL_W (VAL_W),
        .RANGE (RANGE)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .count   (count)
    );

    // used[i] holds the deal count of value i+1
    always_comb begin
        cand_used = '0;
        for (int i = 0; i < RANGE; i++)
            if (cand == VAL_W'(i + 1))
                cand_used = used[i];
    end

    assign avail = cand_used < CAP;
    assign empty = remaining == '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:
                if (accept)
                    next_state = SEARCH;
            SEARCH:
                if (shuffle || avail)
                    next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    // shuffle takes priority over both accepting and dealing
    always_comb begin
        draw_ready = (state == IDLE) && !empty;
        accept     = draw_ready && draw_req && !shuffle;
        deal       = (state == SEARCH) && avail && !shuffle;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand       <= VAL_W'(1);
            card       <= '0;
            card_valid <= 1'b0;
            remaining  <= TOTAL;
        end else begin
            card_valid <= deal;
            if (accept)
                cand <= count;
            else if (state == SEARCH && !avail)
                cand <= VAL_W'(wrap_inc(16'(cand), 2'd1, 16'(RANGE)));
            if (deal)
                card <= cand;
            if (shuffle)
                remaining <= TOTAL;
            else if (deal)
                remaining <= remaining - REM_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RANGE; i++)
                used[i] <= '0;
        end else begin
            for (int i = 0; i < RANGE; i++)
                if (shuffle)
                    used[i] <= '0;
                else if (deal && cand == VAL_W'(i + 1))
                    used[i] <= used[i] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_card_draw_gen.sv
// tb_card_draw_gen: directed checks of card_draw_gen (default build).
// Covers counter wrap, deals, exhaustion search, drain, shuffle, reset.
module tb_card_draw_gen;
    import card_gen_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       shuffle;
    logic       draw_req;
    logic       draw_ready;
    logic [4:0] card;
    logic       card_valid;
    logic [5:0] remaining;
    logic       empty;

    int n_vec;
    int n_err;

    card_draw_gen dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .shuffle    (shuffle),
        .draw_req   (draw_req),
        .draw_ready (draw_ready),
        .card       (card),
        .card_valid (card_valid),
        .remaining  (remaining),
        .empty      (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic move(input int k);
        enable = 1'b1;
        repeat (k) step();
        enable = 1'b0;
    endtask

    task automatic draw(input string tag, input int exp_card,
                        input int exp_lat, input int exp_rem,
                        output logic e_at, output logic r_at);
        int n;
        draw_req = 1'b1;
        step();
        n = 1;
        draw_req = 1'b0;
        while (!card_valid && n < 20) begin
            step();
            n++;
        end
        e_at = empty;
        r_at = draw_ready;
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_card"}, 32'(card), 32'(exp_card));
        check({tag, "_rem"}, 32'(remaining), 32'(exp_rem));
        step();
        check({tag, "_vpulse"}, 32'(card_valid), 32'(0));
    endtask

    task automatic quiet(input string tag, input int k);
        logic seen;
        seen = 1'b0;
        repeat (k) begin
            step();
            if (card_valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'(0));
    endtask

    initial begin
        logic e_at;
        logic r_at;
        int   g;
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        shuffle  = 1'b0;
        draw_req = 1'b0;
        step();
        step();
        check("rst_card", 32'(card), 32'(0));
        check("rst_valid", 32'(card_valid), 32'(0));
        check("rst_rem", 32'(remaining), 32'(40));
        check("rst_empty", 32'(empty), 32'(0));
        check("rst_count", 32'(dut.count), 32'(1));
        reset_n = 1'b1;
        step();
        check("rst_ready", 32'(draw_ready), 32'(1));

        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("cnt%0d", i), 32'(dut.count),
                  32'((i % 10) + 1));
            if (i < 11) step();
        end
        check("cnt_card", 32'(card), 32'(0));
        check("cnt_rem", 32'(remaining), 32'(40));
        repeat (5) step();
        enable = 1'b0;
        check("cnt_at7", 32'(dut.count), 32'(7));
        step();
        check("cnt_hold", 32'(dut.count), 32'(7));

        draw("d7a", 7, 2, 39, e_at, r_at);
        draw("d7b", 7, 2, 38, e_at, r_at);
        draw("d7c", 7, 2, 37, e_at, r_at);
        draw("d7d", 7, 2, 36, e_at, r_at);
        draw("d7x", 8, 3, 35, e_at, r_at);

        move(3);
        check("cnt_at10", 32'(dut.count), 32'(10));
        for (int i = 0; i < 4; i++)
            draw($sformatf("d10_%0d", i), 10, 2, 34 - i, e_at, r_at);
        move(1);
        check("cnt_at1", 32'(dut.count), 32'(1));
        for (int i = 0; i < 4; i++)
            draw($sformatf("d1_%0d", i), 1, 2, 30 - i, e_at, r_at);
        move(9);
        check("cnt_back10", 32'(dut.count), 32'(10));
        draw("dwrap", 2, 4, 26, e_at, r_at);

        draw_req = 1'b1;
        step();
        draw_req = 1'b0;
        check("sh_insearch", 32'(dut.state), 32'(SEARCH));
        shuffle = 1'b1;
        step();
        shuffle = 1'b0;
        check("sh_valid", 32'(card_valid), 32'(0));
        check("sh_rem", 32'(remaining), 32'(40));
        check("sh_state", 32'(dut.state), 32'(IDLE));
        check("sh_card", 32'(card), 32'(2));
        quiet("sh_quiet", 4);

        for (int j = 0; j < 40; j++) begin
            g = j / 4;
            draw($sformatf("drain%0d", j), (g == 0) ? 10 : g, 2 + g,
                 39 - j, e_at, r_at);
        end
        check("last_empty", 32'(e_at), 32'(1));
        check("last_ready", 32'(r_at), 32'(0));
        draw_req = 1'b1;
        step();
        draw_req = 1'b0;
        quiet("empty_nodeal", 15);
        check("empty_rem", 32'(remaining), 32'(0));

        shuffle = 1'b1;
        step();
        shuffle = 1'b0;
        check("refill_rem", 32'(remaining), 32'(40));
        check("refill_empty", 32'(empty), 32'(0));
        check("refill_ready", 32'(draw_ready), 32'(1));

        shuffle  = 1'b1;
        draw_req = 1'b1;
        step();
        shuffle  = 1'b0;
        draw_req = 1'b0;
        check("both_state", 32'(dut.state), 32'(IDLE));
        quiet("both_quiet", 3);
        check("both_rem", 32'(remaining), 32'(40));

        draw_req = 1'b1;
        step();
        draw_req = 1'b0;
        check("rs_insearch", 32'(dut.state), 32'(SEARCH));
        reset_n = 1'b0;
        #1;
        check("rs_valid", 32'(card_valid), 32'(0));
        check("rs_state", 32'(dut.state), 32'(IDLE));
        check("rs_count", 32'(dut.count), 32'(1));
        quiet("rs_quiet", 2);
        reset_n = 1'b1;
        step();
        check("rs_rem", 32'(remaining), 32'(40));
        check("rs_card", 32'(card), 32'(0));
        check("rs_ready", 32'(draw_ready), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
